// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared types, defaults and config legality check for the PWM controller
package pwm_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pwm_state_e;

    // Values are zero-extended by the caller so one function serves any counter width.
    function automatic logic cfg_legal(input logic [31:0] period, input logic [31:0] high);
        return (period >= 32'd2) && (high <= period);
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - period counter that wraps to zero on its own terminal count
module pwm_period_counter
    import pwm_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [CNT_W-1:0] period_i,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             terminal_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign terminal_o = (cnt_q == period_i - CNT_W'(1));
    assign cnt_next_o = cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (advance_i) begin
            cnt_d = terminal_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - PWM generator with shadowed config applied on period boundaries
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             pwm_out,
    output logic             period_start,
    output logic             busy,
    output logic             cfg_err
);

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] act_p_q, act_p_d, act_h_q, act_h_d;
    logic             act_valid_q, act_valid_d;
    logic [CNT_W-1:0] pend_p_q, pend_p_d, pend_h_q, pend_h_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pwm_q, pwm_d, ps_q, ps_d, busy_q, busy_d, err_q, err_d;

    logic             cnt_clear, cnt_advance, terminal;
    logic [CNT_W-1:0] cnt_next;
    logic             transfer, legal, load;

    // Counter control depends only on the current state to keep the counter out of any comb loop.
    assign cnt_clear   = (state_q == IDLE);
    assign cnt_advance = !cnt_clear;

    pwm_period_counter #(.CNT_W(CNT_W)) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .advance_i  (cnt_advance),
        .period_i   (act_p_q),
        .cnt_next_o (cnt_next),
        .terminal_o (terminal)
    );

    assign transfer  = cfg_valid && !pend_valid_q;
    assign legal     = cfg_legal(32'(cfg_period), 32'(cfg_high));
    assign cfg_ready = !pend_valid_q;

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        act_p_d      = act_p_q;
        act_h_d      = act_h_q;
        act_valid_d  = act_valid_q;
        pend_p_d     = pend_p_q;
        pend_h_d     = pend_h_q;
        pend_valid_d = pend_valid_q;
        err_d        = transfer && !legal;

        case (state_q)
            IDLE: begin
                if (en && (pend_valid_q || act_valid_q)) begin
                    state_d = RUN;
                    load    = pend_valid_q;
                end
            end
            RUN: begin
                if (terminal) begin
                    if (en) load = pend_valid_q;
                    else    state_d = IDLE;
                end else if (!en) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (terminal) begin
                    if (en) begin
                        state_d = RUN;
                        load    = pend_valid_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (en) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            act_p_d      = pend_p_q;
            act_h_d      = pend_h_q;
            act_valid_d  = 1'b1;
            pend_valid_d = 1'b0;
        end
        // A transfer needs an empty shadow, so it never collides with a load.
        if (transfer && legal) begin
            pend_p_d     = cfg_period;
            pend_h_d     = cfg_high;
            pend_valid_d = 1'b1;
        end
    end

    // Outputs are computed from next-cycle count and config so they line up with that cycle.
    always_comb begin
        busy_d = (state_d != IDLE);
        pwm_d  = busy_d && (cnt_next < act_h_d);
        ps_d   = busy_d && (cnt_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            act_p_q      <= '0;
            act_h_q      <= '0;
            act_valid_q  <= 1'b0;
            pend_p_q     <= '0;
            pend_h_q     <= '0;
            pend_valid_q <= 1'b0;
            pwm_q        <= 1'b0;
            ps_q         <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_p_q      <= act_p_d;
            act_h_q      <= act_h_d;
            act_valid_q  <= act_valid_d;
            pend_p_q     <= pend_p_d;
            pend_h_q     <= pend_h_d;
            pend_valid_q <= pend_valid_d;
            pwm_q        <= pwm_d;
            ps_q         <= ps_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign busy         = busy_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb/tb_pwm_duty_ctrl.sv - self-checking bench for pwm_duty_ctrl with a period-level model
module tb_pwm_duty_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, cfg_valid;
    logic [7:0] cfg_period, cfg_high;
    logic       cfg_ready, pwm_out, period_start, busy, cfg_err;

    int checks = 0;
    int failures = 0;

    // Model: whether a period is in progress, its cycle index, active and pending configs.
    int m_run = 0, m_k = 0, m_p = 0, m_h = 0, m_act = 0;
    int m_pend = 0, m_pp = 0, m_ph = 0, m_err = 0;

    logic [15:0] pw_v, ps_v, bz_v;

    pwm_duty_ctrl #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_high     (cfg_high),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int xfer, ok;
        if (rst) begin
            m_run = 0; m_k = 0; m_p = 0; m_h = 0; m_act = 0;
            m_pend = 0; m_pp = 0; m_ph = 0; m_err = 0;
            return;
        end
        xfer = (cfg_valid && !m_pend) ? 1 : 0;
        ok   = (cfg_period >= 2 && cfg_high <= cfg_period) ? 1 : 0;
        if (m_run != 0) begin
            if (m_k == m_p - 1) begin
                m_k = 0;
                if (en) begin
                    if (m_pend != 0) begin
                        m_p = m_pp; m_h = m_ph; m_act = 1; m_pend = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                m_k++;
            end
        end else if (en && (m_pend != 0 || m_act != 0)) begin
            m_run = 1; m_k = 0;
            if (m_pend != 0) begin
                m_p = m_pp; m_h = m_ph; m_act = 1; m_pend = 0;
            end
        end
        if (xfer != 0 && ok != 0) begin
            m_pend = 1; m_pp = int'(cfg_period); m_ph = int'(cfg_high);
        end
        m_err = (xfer != 0 && ok == 0) ? 1 : 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("pwm_out",      int'(pwm_out),      (m_run != 0 && m_k < m_h) ? 1 : 0);
        chk("period_start", int'(period_start), (m_run != 0 && m_k == 0) ? 1 : 0);
        chk("busy",         int'(busy),         m_run);
        chk("cfg_ready",    int'(cfg_ready),    (m_pend == 0) ? 1 : 0);
        chk("cfg_err",      int'(cfg_err),      m_err);
    endtask

    task automatic push(input int p, input int h);
        cfg_valid = 1'b1; cfg_period = 8'(p); cfg_high = 8'(h);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic capture(input int n, output logic [15:0] pw, output logic [15:0] ps,
                           output logic [15:0] bz);
        pw = '0; ps = '0; bz = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            pw = {pw[14:0], pwm_out};
            ps = {ps[14:0], period_start};
            bz = {bz[14:0], busy};
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic run_fresh(input int p, input int h);
        en = 1'b0;
        wait_idle();
        push(p, h);
        en = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
        tick();
        tick();
        chk("lit_reset_ready", int'(cfg_ready), 1);
        chk("lit_reset_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // P=4,H=1 from idle: first period_start one cycle after en is sampled
        push(4, 1);
        en = 1'b1;
        capture(8, pw_v, ps_v, bz_v);
        chk("lit_p4h1_pwm", int'(pw_v[7:0]), 8'b1000_1000);
        chk("lit_p4h1_ps",  int'(ps_v[7:0]), 8'b1000_1000);

        // Config accepted in a terminal cycle takes effect one boundary later
        push(4, 2);
        capture(8, pw_v, ps_v, bz_v);
        chk("lit_term_accept_pwm", int'(pw_v[7:0]), 8'b0001_1001);

        // P=6,H=3 pushed at k=1; a second offer is held while the shadow is full
        tick();
        chk("lit_k1_pwm", int'(pwm_out), 1);
        push(6, 3);
        cfg_valid = 1'b1; cfg_period = 8'd7; cfg_high = 8'd7;
        chk("lit_k2_ready", int'(cfg_ready), 0);
        tick();
        chk("lit_k3_ready", int'(cfg_ready), 0);
        tick();
        cfg_valid = 1'b0;
        chk("lit_load_ready", int'(cfg_ready), 1);
        chk("lit_load_ps", int'(period_start), 1);
        capture(6, pw_v, ps_v, bz_v);
        chk("lit_p6h3_pwm", int'(pw_v[5:0]), 6'b110001);
        capture(6, pw_v, ps_v, bz_v);
        chk("lit_p6_ps", int'(ps_v[5:0]), 6'b000001);

        // Illegal configs pulse cfg_err and leave everything else alone
        push(1, 0);
        chk("lit_err_p1", int'(cfg_err), 1);
        chk("lit_err_ready", int'(cfg_ready), 1);
        push(5, 6);
        chk("lit_err_h_gt_p", int'(cfg_err), 1);
        tick();
        chk("lit_err_clear", int'(cfg_err), 0);
        capture(6, pw_v, ps_v, bz_v);

        // P=5,H=2 with en dropped at k=1: the period completes, then idle
        run_fresh(5, 2);
        tick();
        en = 1'b0;
        capture(5, pw_v, ps_v, bz_v);
        chk("lit_stop_pwm", int'(pw_v[4:0]), 5'b00000);
        chk("lit_stop_busy", int'(bz_v[4:0]), 5'b11100);

        // en re-raised at k=3: no gap before the next period
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        tick();
        tick();
        en = 1'b1;
        tick();
        capture(2, pw_v, ps_v, bz_v);
        chk("lit_resume_ps", int'(ps_v[1:0]), 2'b10);
        chk("lit_resume_busy", int'(bz_v[1:0]), 2'b11);

        // Duty extremes on P=3
        run_fresh(3, 0);
        capture(6, pw_v, ps_v, bz_v);
        chk("lit_h0_pwm", int'(pw_v[5:0]), 6'b000000);
        chk("lit_h0_ps", int'(ps_v[5:0]), 6'b001001);
        run_fresh(3, 3);
        capture(6, pw_v, ps_v, bz_v);
        chk("lit_hp_pwm", int'(pw_v[5:0]), 6'b111111);
        chk("lit_hp_ps", int'(ps_v[5:0]), 6'b001001);

        // Reset at k=2 of a P=8 run discards both configs
        run_fresh(8, 4);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("lit_rst_pwm", int'(pwm_out), 0);
        chk("lit_rst_busy", int'(busy), 0);
        chk("lit_rst_ready", int'(cfg_ready), 1);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("lit_rst_stay_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
